dino_jump_ctrl: RTL and testbench

Per-frame motion controller for the player sprite. Turns a raw jump button into a jump/fall trajectory and drives `sprite_x`/`sprite_y` into `sprite_engine`. Position changes only on the frame tick, so a frame never shows a torn sprite. It sits between the input pins, the VGA timing block (which supplies `frame_tick`) and `sprite_engine`.

---
 rtl/game_pkg.sv | 32 +++
 rtl/btn_sync_edge.sv | 38 +++
 rtl/dino_jump_ctrl.sv | 151 +++++++++++++++
 tb/tb_dino_jump_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module  : game_pkg
// Purpose : Shared game-level types and constants: FSM state encoding,
//           screen and sprite geometry, and default jump physics.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GROUND = 2'b01,
    ST_RISE   = 2'b10,
    ST_FALL   = 2'b11
  } state_t;

  localparam int SPRITE_SIZE = 16;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;

  localparam int POS_W = 10;
  localparam int VEL_W = 5;

  localparam int DEF_SPRITE_X = 64;
  localparam int DEF_GROUND_Y = 400;
  localparam int DEF_JUMP_V0  = 12;
  localparam int DEF_GRAVITY  = 1;
  localparam int DEF_VMAX     = 15;

endpackage : game_pkg
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : btn_sync_edge
// Purpose : Two-flop synchroniser for an asynchronous active-high button,
//           followed by a one-clk rising-edge pulse.
// Ports   : clk       - clock
//           rst_n     - asynchronous active-low reset
//           btn_async - raw button, asynchronous to clk
//           btn_rise  - one-clk pulse on a synchronised rising edge
// Revision: 1.0 - initial release
// ============================================================================
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_async,
  output logic btn_rise
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_async;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign btn_rise = sync2_q & ~prev_q;

endmodule : btn_sync_edge
`default_nettype wire

// File: rtl/dino_jump_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dino_jump_ctrl
// Purpose : Per-frame jump/fall motion controller for the player sprite.
//           Position only moves on frame_tick so a frame never tears.
// Ports   : clk, rst_n      - clock, asynchronous active-low reset
//           frame_tick      - one-clk pulse per frame
//           enable          - game running; low forces IDLE
//           jump_btn        - raw asynchronous jump button
//           sprite_x/_y     - sprite position to sprite_engine
//           state           - current FSM state
//           airborne        - high in RISE or FALL
//           land_pulse      - one-clk pulse on touchdown
// Revision: 1.0 - initial release
// ============================================================================
module dino_jump_ctrl
  import game_pkg::*;
#(
  parameter int SPRITE_X = DEF_SPRITE_X,
  parameter int GROUND_Y = DEF_GROUND_Y,
  parameter int JUMP_V0  = DEF_JUMP_V0,
  parameter int GRAVITY  = DEF_GRAVITY,
  parameter int VMAX     = DEF_VMAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             enable,
  input  logic             jump_btn,
  output logic [POS_W-1:0] sprite_x,
  output logic [POS_W-1:0] sprite_y,
  output logic [1:0]       state,
  output logic             airborne,
  output logic             land_pulse
);

  localparam logic [POS_W-1:0] C_SPRITE_X = POS_W'(SPRITE_X);
  localparam logic [POS_W-1:0] C_GROUND_Y = POS_W'(GROUND_Y);
  localparam logic [VEL_W-1:0] C_JUMP_V0  = VEL_W'(JUMP_V0);
  localparam logic [VEL_W-1:0] C_GRAVITY  = VEL_W'(GRAVITY);
  localparam logic [VEL_W-1:0] C_VMAX     = VEL_W'(VMAX);

  state_t             state_q, state_d;
  logic [POS_W-1:0]   y_q, y_d;
  logic [VEL_W-1:0]   vel_q, vel_d;
  logic               req_q, req_d;
  logic               land_q, land_d;

  logic               btn_rise;
  logic [VEL_W:0]     vel_sum;
  logic [VEL_W-1:0]   vel_fall;
  logic [POS_W:0]     y_fall;

  btn_sync_edge u_btn_sync_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_async (jump_btn),
    .btn_rise  (btn_rise)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    req_d   = req_q;
    land_d  = 1'b0;

    // Falling speed saturates at VMAX; the sum is one bit wider so it
    // cannot wrap before the comparison.
    vel_sum  = {1'b0, vel_q} + {1'b0, C_GRAVITY};
    vel_fall = (vel_sum > {1'b0, C_VMAX}) ? C_VMAX : vel_sum[VEL_W-1:0];
    y_fall   = {1'b0, y_q} + {{(POS_W+1-VEL_W){1'b0}}, vel_fall};

    if (!enable) begin
      state_d = ST_IDLE;
      y_d     = C_GROUND_Y;
      vel_d   = '0;
      req_d   = 1'b0;
    end else begin
      // Only a grounded sprite may queue a jump; edges elsewhere are lost.
      if (state_q == ST_GROUND && btn_rise) begin
        req_d = 1'b1;
      end
      if (frame_tick) begin
        case (state_q)
          ST_IDLE: state_d = ST_GROUND;
          ST_GROUND: begin
            // Clearing here also discards an edge arriving on the launch clk.
            if (req_q) begin
              state_d = ST_RISE;
              vel_d   = C_JUMP_V0;
              req_d   = 1'b0;
            end
          end
          ST_RISE: begin
            if (y_q < {{(POS_W-VEL_W){1'b0}}, vel_q}) begin
              // Hit the top of the screen: stop dead and start falling.
              y_d     = '0;
              vel_d   = '0;
              state_d = ST_FALL;
            end else begin
              y_d = y_q - {{(POS_W-VEL_W){1'b0}}, vel_q};
              if (vel_q <= C_GRAVITY) begin
                vel_d   = '0;
                state_d = ST_FALL;
              end else begin
                vel_d = vel_q - C_GRAVITY;
              end
            end
          end
          ST_FALL: begin
            if (y_fall >= {1'b0, C_GROUND_Y}) begin
              y_d     = C_GROUND_Y;
              vel_d   = '0;
              state_d = ST_GROUND;
              land_d  = 1'b1;
            end else begin
              y_d   = y_fall[POS_W-1:0];
              vel_d = vel_fall;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      y_q     <= C_GROUND_Y;
      vel_q   <= '0;
      req_q   <= 1'b0;
      land_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      req_q   <= req_d;
      land_q  <= land_d;
    end
  end

  assign sprite_x   = C_SPRITE_X;
  assign sprite_y   = y_q;
  assign state      = state_q;
  assign airborne   = state_q[1];
  assign land_pulse = land_q;

endmodule : dino_jump_ctrl
`default_nettype wire

// File: tb/tb_dino_jump_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dino_jump_ctrl
// Purpose : Directed self-checking bench for dino_jump_ctrl. Instance a uses
//           default physics, b a low ground (ceiling), c a mid ground (cap).
// Revision: 1.0 - initial release
// ============================================================================
module tb_dino_jump_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic frame_tick;
  logic en_a, en_b, en_c;
  logic btn_a, btn_b, btn_c;

  logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic [1:0] st_a, st_b, st_c;
  logic       air_a, air_b, air_c;
  logic       land_a, land_b, land_c;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dino_jump_ctrl u_dut_a (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(en_a),
    .jump_btn(btn_a), .sprite_x(x_a), .sprite_y(y_a), .state(st_a),
    .airborne(air_a), .land_pulse(land_a)
  );

  dino_jump_ctrl #(.GROUND_Y(40), .JUMP_V0(31), .GRAVITY(1), .VMAX(15)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(en_b),
    .jump_btn(btn_b), .sprite_x(x_b), .sprite_y(y_b), .state(st_b),
    .airborne(air_b), .land_pulse(land_b)
  );

  dino_jump_ctrl #(.GROUND_Y(200), .JUMP_V0(31), .GRAVITY(1), .VMAX(15)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(en_c),
    .jump_btn(btn_c), .sprite_x(x_c), .sprite_y(y_c), .state(st_c),
    .airborne(air_c), .land_pulse(land_c)
  );

  // One frame tick, returning on the negedge right after it is captured.
  task automatic do_tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic press(input int which);
    @(negedge clk);
    if (which == 0) btn_a = 1'b1; else if (which == 1) btn_b = 1'b1; else btn_c = 1'b1;
    repeat (4) @(negedge clk);
    btn_a = 1'b0; btn_b = 1'b0; btn_c = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    n_total++; if (st_a !== 2'b00) $display("FAIL reset_state: got %0d expected 0", st_a); else n_pass++;
    n_total++; if (y_a !== 10'd400) $display("FAIL reset_y: got %0d expected 400", y_a); else n_pass++;
    n_total++; if (x_a !== 10'd64) $display("FAIL reset_x: got %0d expected 64", x_a); else n_pass++;
    n_total++; if (land_a !== 1'b0 || air_a !== 1'b0) $display("FAIL reset_flags: got land=%0b air=%0b expected 0 0", land_a, air_a); else n_pass++;
  endtask

  task automatic test_startup();
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    do_tick();
    n_total++; if (st_a !== 2'b01) $display("FAIL startup_ground: got %0d expected 1", st_a); else n_pass++;
    for (int i = 0; i < 5; i++) do_tick();
    n_total++; if (st_a !== 2'b01 || y_a !== 10'd400) $display("FAIL startup_hold: got st=%0d y=%0d expected 1 400", st_a, y_a); else n_pass++;
  endtask

  task automatic test_full_jump();
    int exp_y [24] = '{388,377,367,358,350,343,337,332,328,325,323,322,
                       323,325,328,332,337,343,350,358,367,377,388,400};
    logic [1:0] exp_st;
    press(0);
    do_tick();
    n_total++; if (st_a !== 2'b10 || y_a !== 10'd400 || air_a !== 1'b1) $display("FAIL launch: got st=%0d y=%0d air=%0b expected 2 400 1", st_a, y_a, air_a); else n_pass++;
    for (int i = 0; i < 24; i++) begin
      do_tick();
      exp_st = (i < 11) ? 2'b10 : (i < 23) ? 2'b11 : 2'b01;
      n_total++; if (y_a !== 10'(exp_y[i]) || st_a !== exp_st) $display("FAIL jump_step%0d: got y=%0d st=%0d expected y=%0d st=%0d", i, y_a, st_a, exp_y[i], exp_st); else n_pass++;
      n_total++; if (land_a !== (i == 23)) $display("FAIL jump_land%0d: got %0b expected %0b", i, land_a, (i == 23)); else n_pass++;
    end
    @(negedge clk);
    n_total++; if (land_a !== 1'b0) $display("FAIL land_one_clk: got %0b expected 0", land_a); else n_pass++;
  endtask

  task automatic test_airborne_press();
    press(0);
    do_tick();
    for (int i = 0; i < 3; i++) do_tick();
    press(0);                       // in RISE
    for (int i = 0; i < 12; i++) do_tick();
    n_total++; if (st_a !== 2'b11) $display("FAIL air_in_fall: got %0d expected 3", st_a); else n_pass++;
    press(0);                       // in FALL
    for (int i = 0; i < 9; i++) do_tick();
    n_total++; if (st_a !== 2'b01 || y_a !== 10'd400) $display("FAIL air_landed: got st=%0d y=%0d expected 1 400", st_a, y_a); else n_pass++;
    for (int i = 0; i < 3; i++) do_tick();
    n_total++; if (st_a !== 2'b01 || y_a !== 10'd400) $display("FAIL no_relaunch: got st=%0d y=%0d expected 1 400", st_a, y_a); else n_pass++;
  endtask

  task automatic test_disable();
    press(0);
    do_tick();
    for (int i = 0; i < 19; i++) do_tick();
    n_total++; if (st_a !== 2'b11 || y_a !== 10'd350) $display("FAIL dis_pre: got st=%0d y=%0d expected 3 350", st_a, y_a); else n_pass++;
    @(negedge clk); en_a = 1'b0;
    @(negedge clk);
    n_total++; if (st_a !== 2'b00 || y_a !== 10'd400 || land_a !== 1'b0 || air_a !== 1'b0) $display("FAIL dis_idle: got st=%0d y=%0d land=%0b air=%0b expected 0 400 0 0", st_a, y_a, land_a, air_a); else n_pass++;
    en_a = 1'b1;
    do_tick();
    n_total++; if (st_a !== 2'b01) $display("FAIL dis_reenable: got %0d expected 1", st_a); else n_pass++;
  endtask

  task automatic test_reset_mid();
    press(0);
    do_tick();
    for (int i = 0; i < 3; i++) do_tick();
    n_total++; if (y_a !== 10'd367) $display("FAIL rst_pre: got %0d expected 367", y_a); else n_pass++;
    @(negedge clk); #2 rst_n = 1'b0; #1;
    n_total++; if (st_a !== 2'b00 || y_a !== 10'd400 || x_a !== 10'd64 || land_a !== 1'b0) $display("FAIL rst_mid: got st=%0d y=%0d x=%0d land=%0b expected 0 400 64 0", st_a, y_a, x_a, land_a); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    do_tick();
    n_total++; if (st_a !== 2'b01 || st_b !== 2'b01 || st_c !== 2'b01) $display("FAIL rst_ground: got a=%0d b=%0d c=%0d expected 1 1 1", st_a, st_b, st_c); else n_pass++;
  endtask

  task automatic test_ceiling();
    int exp_y [11] = '{9,0,1,3,6,10,15,21,28,36,40};
    logic [1:0] exp_st;
    press(1);
    do_tick();
    n_total++; if (st_b !== 2'b10 || y_b !== 10'd40) $display("FAIL ceil_launch: got st=%0d y=%0d expected 2 40", st_b, y_b); else n_pass++;
    for (int i = 0; i < 11; i++) begin
      do_tick();
      exp_st = (i == 0) ? 2'b10 : (i < 10) ? 2'b11 : 2'b01;
      n_total++; if (y_b !== 10'(exp_y[i]) || st_b !== exp_st || land_b !== (i == 10)) $display("FAIL ceil_step%0d: got y=%0d st=%0d land=%0b expected y=%0d st=%0d land=%0b", i, y_b, st_b, land_b, exp_y[i], exp_st, (i == 10)); else n_pass++;
    end
  endtask

  task automatic test_cap();
    int exp_y [29] = '{169,139,110,82,55,29,4,0,
                       1,3,6,10,15,21,28,36,45,55,66,78,91,105,120,
                       135,150,165,180,195,200};
    logic [1:0] exp_st;
    press(2);
    do_tick();
    for (int i = 0; i < 29; i++) begin
      do_tick();
      exp_st = (i < 7) ? 2'b10 : (i < 28) ? 2'b11 : 2'b01;
      n_total++; if (y_c !== 10'(exp_y[i]) || st_c !== exp_st || land_c !== (i == 28)) $display("FAIL cap_step%0d: got y=%0d st=%0d land=%0b expected y=%0d st=%0d land=%0b", i, y_c, st_c, land_c, exp_y[i], exp_st, (i == 28)); else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    btn_a = 1'b0; btn_b = 1'b0; btn_c = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_startup();
    test_full_jump();
    test_airborne_press();
    test_disable();
    test_reset_mid();
    test_ceiling();
    test_cap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_dino_jump_ctrl
`default_nettype wire
